// File: rtl/traffic_light_sequencer_if.sv
// Signal bundle between a traffic-light sequencer and the logic that controls
// and observes it; the sequencer takes the slave side.
interface traffic_light_sequencer_if;
    logic        enable;
    logic        ped_request;
    logic        maintenance;
    logic        red;
    logic        yellow;
    logic        green;
    logic        walk;
    logic        ped_pending;
    logic        state_change;
    logic [31:0] clock_ticks;

    modport master (
        output enable,
        output ped_request,
        output maintenance,
        input  red,
        input  yellow,
        input  green,
        input  walk,
        input  ped_pending,
        input  state_change,
        input  clock_ticks
    );

    modport slave (
        input  enable,
        input  ped_request,
        input  maintenance,
        output red,
        output yellow,
        output green,
        output walk,
        output ped_pending,
        output state_change,
        output clock_ticks
    );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Single-approach traffic-light sequencer: RED -> GREEN -> YELLOW cycle with a
// remaining-tick countdown, pedestrian green truncation and a flashing-yellow mode.
module traffic_light_sequencer #(
    parameter logic [31:0] RED_TICKS       = 32'd500000000,
    parameter logic [31:0] GREEN_TICKS     = 32'd500000000,
    parameter logic [31:0] YELLOW_TICKS    = 32'd150000000,
    parameter logic [31:0] PED_GREEN_TICKS = 32'd100000000,
    parameter logic [31:0] FLASH_TICKS     = 32'd25000000
) (
    input logic                      clock,
    input logic                      reset_n,
    traffic_light_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_ticks;
    logic [31:0] r_flashCnt;
    logic        r_red;
    logic        r_yellow;
    logic        r_green;
    logic        r_walk;
    logic        r_pending;
    logic        r_stateChange;

    state_t      w_nextState;
    logic [31:0] w_nextTicks;
    logic [31:0] w_nextFlashCnt;
    logic        w_nextRed;
    logic        w_nextYellow;
    logic        w_nextGreen;
    logic        w_nextWalk;
    logic        w_nextPending;
    logic        w_nextStateChange;

    // Maintenance outranks everything, including a countdown that ends this cycle.
    always_comb begin
        w_nextState       = r_state;
        w_nextTicks       = r_ticks;
        w_nextFlashCnt    = r_flashCnt;
        w_nextRed         = r_red;
        w_nextYellow      = r_yellow;
        w_nextGreen       = r_green;
        w_nextWalk        = r_walk;
        w_nextPending     = r_pending | (bus.ped_request & ~r_walk);
        w_nextStateChange = 1'b0;

        if (bus.maintenance) begin
            w_nextPending = 1'b0;
            if (r_state != ST_FLASH) begin
                w_nextState       = ST_FLASH;
                w_nextTicks       = 32'd0;
                w_nextFlashCnt    = 32'd0;
                w_nextRed         = 1'b0;
                w_nextYellow      = 1'b1;
                w_nextGreen       = 1'b0;
                w_nextWalk        = 1'b0;
                w_nextStateChange = 1'b1;
            end else if (r_flashCnt == FLASH_TICKS - 32'd1) begin
                w_nextYellow   = ~r_yellow;
                w_nextFlashCnt = 32'd0;
            end else begin
                w_nextFlashCnt = r_flashCnt + 32'd1;
            end
        end else if (r_state == ST_FLASH) begin
            w_nextState       = ST_RED;
            w_nextTicks       = RED_TICKS - 32'd1;
            w_nextFlashCnt    = 32'd0;
            w_nextRed         = 1'b1;
            w_nextYellow      = 1'b0;
            w_nextGreen       = 1'b0;
            w_nextWalk        = 1'b0;
            w_nextPending     = 1'b0;
            w_nextStateChange = 1'b1;
        end else if (bus.enable) begin
            if (r_ticks == 32'd0) begin
                w_nextStateChange = 1'b1;
                case (r_state)
                    ST_RED: begin
                        w_nextState  = ST_GREEN;
                        w_nextTicks  = GREEN_TICKS - 32'd1;
                        w_nextRed    = 1'b0;
                        w_nextYellow = 1'b0;
                        w_nextGreen  = 1'b1;
                        w_nextWalk   = 1'b0;
                    end
                    ST_GREEN: begin
                        w_nextState  = ST_YELLOW;
                        w_nextTicks  = YELLOW_TICKS - 32'd1;
                        w_nextRed    = 1'b0;
                        w_nextYellow = 1'b1;
                        w_nextGreen  = 1'b0;
                    end
                    default: begin
                        // A request arriving on this very edge is served, not re-latched.
                        w_nextState   = ST_RED;
                        w_nextTicks   = RED_TICKS - 32'd1;
                        w_nextRed     = 1'b1;
                        w_nextYellow  = 1'b0;
                        w_nextGreen   = 1'b0;
                        w_nextWalk    = r_pending | bus.ped_request;
                        w_nextPending = 1'b0;
                    end
                endcase
            end else if ((r_state == ST_GREEN) && r_pending &&
                         (r_ticks > PED_GREEN_TICKS - 32'd1)) begin
                w_nextTicks = PED_GREEN_TICKS - 32'd1;
            end else begin
                w_nextTicks = r_ticks - 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RED;
            r_ticks       <= RED_TICKS - 32'd1;
            r_flashCnt    <= 32'd0;
            r_red         <= 1'b1;
            r_yellow      <= 1'b0;
            r_green       <= 1'b0;
            r_walk        <= 1'b0;
            r_pending     <= 1'b0;
            r_stateChange <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_ticks       <= w_nextTicks;
            r_flashCnt    <= w_nextFlashCnt;
            r_red         <= w_nextRed;
            r_yellow      <= w_nextYellow;
            r_green       <= w_nextGreen;
            r_walk        <= w_nextWalk;
            r_pending     <= w_nextPending;
            r_stateChange <= w_nextStateChange;
        end
    end

    assign bus.red          = r_red;
    assign bus.yellow       = r_yellow;
    assign bus.green        = r_green;
    assign bus.walk         = r_walk;
    assign bus.ped_pending  = r_pending;
    assign bus.state_change = r_stateChange;
    assign bus.clock_ticks  = r_ticks;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with short durations; outputs are
// sampled on the falling clock edge and compared against hand-computed values.
module tb_traffic_light_sequencer;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic clock;
    logic reset_n;
    int   vectorCount;
    int   missCount;

    traffic_light_sequencer_if bus ();

    traffic_light_sequencer #(
        .RED_TICKS      (32'd8),
        .GREEN_TICKS    (32'd10),
        .YELLOW_TICKS   (32'd4),
        .PED_GREEN_TICKS(32'd3),
        .FLASH_TICKS    (32'd2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkState(input string tag, input logic [2:0] lamps, input int ticks, input bit sc);
        checkOutput({tag, ":lamps"}, {29'd0, bus.red, bus.yellow, bus.green}, {29'd0, lamps});
        checkOutput({tag, ":ticks"}, bus.clock_ticks, ticks);
        checkOutput({tag, ":state_change"}, {31'd0, bus.state_change}, {31'd0, sc});
    endtask

    // Advance one cycle per count value from hi down to lo; entry flags the first as a state entry.
    task automatic applyStimulus(input string tag, input logic [2:0] lamps, input int hi, input int lo, input bit entry);
        for (int i = hi; i >= lo; i--) begin
            nextCycle();
            checkState(tag, lamps, i, entry && (i == hi));
        end
    endtask

    task automatic checkPed(input string tag, input bit walk, input bit pending);
        checkOutput({tag, ":walk"}, {31'd0, bus.walk}, {31'd0, walk});
        checkOutput({tag, ":ped_pending"}, {31'd0, bus.ped_pending}, {31'd0, pending});
    endtask

    initial begin
        vectorCount         = 0;
        missCount           = 0;
        reset_n             = 1'b0;
        bus.enable          = 1'b1;
        bus.ped_request     = 1'b0;
        bus.maintenance     = 1'b0;

        @(negedge clock);
        checkState("reset", L_RED, 7, 1'b0);
        checkPed("reset", 1'b0, 1'b0);
        reset_n = 1'b1;

        // Free run through a whole cycle.
        applyStimulus("free_red", L_RED, 6, 0, 1'b0);
        applyStimulus("free_grn", L_GRN, 9, 0, 1'b1);
        applyStimulus("free_yel", L_YEL, 3, 0, 1'b1);
        applyStimulus("free_red2", L_RED, 7, 7, 1'b1);
        checkPed("free_red2", 1'b0, 1'b0);

        // Request at GREEN 8 truncates to 2 two edges later.
        applyStimulus("ped_red", L_RED, 6, 0, 1'b0);
        applyStimulus("ped_grn", L_GRN, 9, 8, 1'b1);
        bus.ped_request = 1'b1;
        nextCycle();
        checkState("ped_latch", L_GRN, 7, 1'b0);
        checkPed("ped_latch", 1'b0, 1'b1);
        bus.ped_request = 1'b0;
        nextCycle();
        checkState("ped_trunc", L_GRN, 2, 1'b0);
        applyStimulus("ped_grn_end", L_GRN, 1, 0, 1'b0);
        applyStimulus("ped_yel", L_YEL, 3, 3, 1'b1);
        checkPed("ped_yel", 1'b0, 1'b1);
        applyStimulus("ped_yel_end", L_YEL, 2, 0, 1'b0);
        applyStimulus("ped_walk", L_RED, 7, 7, 1'b1);
        checkPed("ped_walk", 1'b1, 1'b0);
        applyStimulus("ped_walk_red", L_RED, 6, 0, 1'b0);
        checkPed("ped_walk_hold", 1'b1, 1'b0);
        applyStimulus("ped_walk_off", L_GRN, 9, 9, 1'b1);
        checkPed("ped_walk_off", 1'b0, 1'b0);

        // Request at GREEN 1 is too late to shorten anything.
        applyStimulus("late_grn", L_GRN, 8, 1, 1'b0);
        bus.ped_request = 1'b1;
        applyStimulus("late_last", L_GRN, 0, 0, 1'b0);
        checkPed("late_last", 1'b0, 1'b1);
        bus.ped_request = 1'b0;
        applyStimulus("late_yel", L_YEL, 3, 0, 1'b1);
        applyStimulus("late_red", L_RED, 7, 7, 1'b1);
        checkPed("late_red", 1'b1, 1'b0);
        applyStimulus("late_red_run", L_RED, 6, 0, 1'b0);
        applyStimulus("late_grn2", L_GRN, 9, 9, 1'b1);
        checkPed("late_grn2", 1'b0, 1'b0);

        // Pause at YELLOW 2 for five cycles.
        applyStimulus("pause_grn", L_GRN, 8, 0, 1'b0);
        applyStimulus("pause_yel", L_YEL, 3, 2, 1'b1);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus("pause_hold", L_YEL, 2, 2, 1'b0);
        bus.enable = 1'b1;
        applyStimulus("pause_resume", L_YEL, 1, 0, 1'b0);
        applyStimulus("pause_red", L_RED, 7, 7, 1'b1);

        // Maintenance entered from GREEN with a request pending.
        applyStimulus("mnt_red", L_RED, 6, 0, 1'b0);
        applyStimulus("mnt_grn", L_GRN, 9, 9, 1'b1);
        bus.ped_request = 1'b1;
        applyStimulus("mnt_grn8", L_GRN, 8, 8, 1'b0);
        bus.ped_request = 1'b0;
        checkPed("mnt_pend", 1'b0, 1'b1);
        bus.maintenance = 1'b1;
        nextCycle();
        checkState("mnt_enter", L_YEL, 0, 1'b1);
        checkPed("mnt_enter", 1'b0, 1'b0);
        nextCycle();
        checkState("mnt_f1", L_YEL, 0, 1'b0);
        bus.ped_request = 1'b1;
        nextCycle();
        checkState("mnt_f2", L_OFF, 0, 1'b0);
        checkPed("mnt_f2", 1'b0, 1'b0);
        nextCycle();
        checkState("mnt_f3", L_OFF, 0, 1'b0);
        checkPed("mnt_f3", 1'b0, 1'b0);
        bus.ped_request = 1'b0;
        nextCycle();
        checkState("mnt_f4", L_YEL, 0, 1'b0);
        bus.maintenance = 1'b0;
        applyStimulus("mnt_exit", L_RED, 7, 7, 1'b1);
        checkPed("mnt_exit", 1'b0, 1'b0);

        // Asynchronous reset between edges while GREEN is truncated and a request is pending.
        applyStimulus("rst_red", L_RED, 6, 0, 1'b0);
        applyStimulus("rst_grn", L_GRN, 9, 9, 1'b1);
        bus.ped_request = 1'b1;
        applyStimulus("rst_grn8", L_GRN, 8, 8, 1'b0);
        bus.ped_request = 1'b0;
        nextCycle();
        checkState("rst_trunc", L_GRN, 2, 1'b0);
        checkPed("rst_trunc", 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkState("rst_async", L_RED, 7, 1'b0);
        checkPed("rst_async", 1'b0, 1'b0);
        @(negedge clock);
        checkState("rst_held", L_RED, 7, 1'b0);
        reset_n = 1'b1;
        applyStimulus("rst_release", L_RED, 6, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Sequencer for one traffic-light approach: steps through RED → GREEN → YELLOW → RED with per-state durations counted in clock cycles. It drives the lamp outputs and a pedestrian WALK lamp. Its `clock_ticks` output is the remaining-tick count of the current state and feeds the seconds countdown display directly, which shows `clock_ticks / SCALER + 1`. It also supports pedestrian-request green truncation, pause, and a maintenance flashing-yellow mode.

## Interface
Parameters:
- `RED_TICKS`, 32'd500000000 — RED duration in cycles (10 s at 50 MHz)
- `GREEN_TICKS`, 32'd500000000 — GREEN duration in cycles
- `YELLOW_TICKS`, 32'd150000000 — YELLOW duration in cycles
- `PED_GREEN_TICKS`, 32'd100000000 — maximum remaining GREEN once a pedestrian request is pending
- `FLASH_TICKS`, 32'd25000000 — half-period of the maintenance yellow blink

Ports:
- `clock` in 1 — sole clock, rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `enable` in 1 — 1 = run; 0 = freeze counter and state
- `ped_request` in 1 — pedestrian button, level-sampled every cycle
- `maintenance` in 1 — 1 = flashing-yellow mode
- `red`, `yellow`, `green` out 1 — lamp drives
- `walk` out 1 — pedestrian WALK lamp
- `ped_pending` out 1 — a request is latched and not yet served
- `state_change` out 1 — one-cycle pulse on every state entry except reset
- `clock_ticks` out 32 — remaining ticks in the current state, to the display stage

## Operation
- States: RED, GREEN, YELLOW, FLASH. All outputs are registered.
- Reset (async, while `reset_n`=0):
  - State = RED, `clock_ticks` = RED_TICKS-1, `red`=1.
  - All other outputs 0.
- Countdown:
  - On state entry, `clock_ticks` loads DUR-1.
  - It decrements by 1 per cycle while `enable`=1.
  - In the cycle after it reads 0, the next state is entered with its own DUR-1.
  - Each state therefore lasts exactly DUR enabled cycles.
  - Wrap below 0 never occurs.
- Transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED.
- Exactly one of `red`/`yellow`/`green` is 1 outside FLASH.
- Pedestrian request latch:
  - `ped_pending` next = `ped_pending` | (`ped_request` & ~`walk`).
  - On the YELLOW→RED transition, `walk` is set to 1 if `ped_pending`=1 or `ped_request`=1 that cycle.
  - On that same transition, `ped_pending` clears; a request arriving in that cycle is consumed, not re-latched.
  - `walk` clears on RED exit.
- Green truncation:
  - Applies in GREEN with `enable`=1 and `ped_pending`=1.
  - If `clock_ticks` > PED_GREEN_TICKS-1, `clock_ticks` loads PED_GREEN_TICKS-1 instead of decrementing.
  - Otherwise the normal decrement applies.
- `enable`=0:
  - `clock_ticks` and state hold; no truncation.
  - `ped_request` is still latched.
- Maintenance (FLASH):
  - `maintenance`=1 forces FLASH on the next edge from any state, regardless of `enable`.
  - Entering FLASH: `red`=`green`=`walk`=0, `yellow`=1, `clock_ticks`=0, `ped_pending` cleared.
  - In FLASH, `ped_request` is ignored.
  - An internal counter toggles `yellow` every FLASH_TICKS cycles.
  - `maintenance`=0 returns to RED with RED_TICKS-1 on the next edge and pulses `state_change`.
- Arithmetic: 32-bit unsigned throughout.
- Legal parameter range: all durations ≥ 2, PED_GREEN_TICKS ≤ GREEN_TICKS. Behaviour outside this range is undefined.

## Timing
- Request-to-`ped_pending` latency: 1 cycle.
- Request-to-truncation latency: the truncation load occurs on the edge after `ped_pending` rises, i.e. the 2nd edge after `ped_request` is sampled.
- Lamp outputs and `clock_ticks` change on the same edge as the state.
- `state_change` is high for that single cycle.
- `reset_n` asserted mid-state: all outputs return to reset values immediately (async).
  - After deassertion, the first rising edge begins counting down RED.
- Simultaneous `maintenance` rise and state-end: FLASH wins. No intermediate state is entered and there is one `state_change` pulse.

## Test plan
Overrides for all scenarios: RED=8, GREEN=10, YELLOW=4, PED_GREEN=3, FLASH=2.

- Free run, `enable`=1:
  - Expect `red` for 8 cycles with `clock_ticks` 7..0, then `green` for 10 cycles (9..0), then `yellow` for 4 cycles (3..0), then `red`.
  - Expect a `state_change` pulse at each entry.
- Pedestrian truncation: 1-cycle `ped_request` when GREEN `clock_ticks`=8.
  - `ped_pending`=1 next cycle; `clock_ticks` reloads to 2 on the following edge.
  - Then 1, 0, YELLOW.
  - RED entered with `walk`=1 and `ped_pending`=0.
  - `walk` falls on GREEN entry.
- Late request: `ped_request` when GREEN `clock_ticks`=1.
  - No reload; GREEN ends normally.
  - `walk`=1 in the following RED.
- Pause: `enable`=0 for 5 cycles at YELLOW `clock_ticks`=2.
  - Value and state hold at 2 for those 5 cycles.
  - Countdown then resumes 1, 0, RED.
- Maintenance during GREEN:
  - Next edge: `yellow`=1, `green`=0, `clock_ticks`=0.
  - `yellow` toggles every 2 cycles.
  - On deassert, next edge enters RED with `clock_ticks`=7.
- Async reset: pulse `reset_n` low mid-GREEN between edges.
  - Outputs go to RED/7 immediately.
  - `walk`, `ped_pending`, and `state_change` are 0.
